// File: rtl/output_layer_backprop.sv
// ============================================================================
// output_layer_backprop
// ----------------------------------------------------------------------------
// Backward pass for a 3-input / 2-output signed fixed-point output layer.
// One signed multiplier is shared across all products and is sequenced by a
// small FSM. The FSM uses a start/done handshake.
//
// Optional feature (macro OUTPUT_BACKPROP_SIGMOID_DERIV_EN):
//   When the macro is defined, a DERIV state scales each error by the sigmoid
//   derivative out*(1-out). When it is undefined, the output layer is linear
//   and delta = out - target.
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-low reset
//   start                request, sampled only in IDLE
//   A, B, C              forward-pass layer inputs
//   out1, out2           forward-pass outputs
//   t1, t2               targets
//   wa1..wc2             current weights (wXk = input X to output k)
//   bias1, bias2         current biases
//   lr                   learning rate
//   busy                 high from accepted start until done
//   done                 one-cycle pulse, results valid
//   delta1, delta2       output deltas
//   wa1_n..wc2_n         updated weights
//   bias1_n, bias2_n     updated biases
//   errA, errB, errC     back-propagated error per input
// ============================================================================
module output_layer_backprop #(
    parameter int DWIDTH = 32,
    parameter int frac   = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic signed [DWIDTH-1:0] A,
    input  logic signed [DWIDTH-1:0] B,
    input  logic signed [DWIDTH-1:0] C,
    input  logic signed [DWIDTH-1:0] out1,
    input  logic signed [DWIDTH-1:0] out2,
    input  logic signed [DWIDTH-1:0] t1,
    input  logic signed [DWIDTH-1:0] t2,
    input  logic signed [DWIDTH-1:0] wa1,
    input  logic signed [DWIDTH-1:0] wa2,
    input  logic signed [DWIDTH-1:0] wb1,
    input  logic signed [DWIDTH-1:0] wb2,
    input  logic signed [DWIDTH-1:0] wc1,
    input  logic signed [DWIDTH-1:0] wc2,
    input  logic signed [DWIDTH-1:0] bias1,
    input  logic signed [DWIDTH-1:0] bias2,
    input  logic signed [DWIDTH-1:0] lr,
    output logic                     busy,
    output logic                     done,
    output logic signed [DWIDTH-1:0] delta1,
    output logic signed [DWIDTH-1:0] delta2,
    output logic signed [DWIDTH-1:0] wa1_n,
    output logic signed [DWIDTH-1:0] wa2_n,
    output logic signed [DWIDTH-1:0] wb1_n,
    output logic signed [DWIDTH-1:0] wb2_n,
    output logic signed [DWIDTH-1:0] wc1_n,
    output logic signed [DWIDTH-1:0] wc2_n,
    output logic signed [DWIDTH-1:0] bias1_n,
    output logic signed [DWIDTH-1:0] bias2_n,
    output logic signed [DWIDTH-1:0] errA,
    output logic signed [DWIDTH-1:0] errB,
    output logic signed [DWIDTH-1:0] errC
);

    localparam logic signed [DWIDTH-1:0] MAXV = {1'b0, {(DWIDTH-1){1'b1}}};
    localparam logic signed [DWIDTH-1:0] MINV = {1'b1, {(DWIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
`ifdef OUTPUT_BACKPROP_SIGMOID_DERIV_EN
        DERIV = 3'd2,
`endif
        SCALE = 3'd3,
        WUPD  = 3'd4,
        BPROP = 3'd5,
        DONE  = 3'd6
    } state_t;

    // Saturating add/sub: compute at DWIDTH+1 bits. If the two top bits
    // differ, the result overflowed in the direction given by the top bit.
    function automatic logic signed [DWIDTH-1:0] satAdd(
        input logic signed [DWIDTH-1:0] a, input logic signed [DWIDTH-1:0] b);
        logic signed [DWIDTH:0] s;
        s = {a[DWIDTH-1], a} + {b[DWIDTH-1], b};
        if (s[DWIDTH] != s[DWIDTH-1]) return s[DWIDTH] ? MINV : MAXV;
        return s[DWIDTH-1:0];
    endfunction

    function automatic logic signed [DWIDTH-1:0] satSub(
        input logic signed [DWIDTH-1:0] a, input logic signed [DWIDTH-1:0] b);
        logic signed [DWIDTH:0] s;
        s = {a[DWIDTH-1], a} - {b[DWIDTH-1], b};
        if (s[DWIDTH] != s[DWIDTH-1]) return s[DWIDTH] ? MINV : MAXV;
        return s[DWIDTH-1:0];
    endfunction

    // Full-width product, truncating arithmetic shift, and then saturation.
    // The shifted value fits in DWIDTH bits only when all of its bits from
    // the DWIDTH-1 position upward are equal.
    function automatic logic signed [DWIDTH-1:0] satMul(
        input logic signed [DWIDTH-1:0] a, input logic signed [DWIDTH-1:0] b);
        logic signed [2*DWIDTH-1:0] ax, bx, p, sh;
        ax = {{DWIDTH{a[DWIDTH-1]}}, a};
        bx = {{DWIDTH{b[DWIDTH-1]}}, b};
        p  = ax * bx;
        sh = p >>> frac;
        if ((&sh[2*DWIDTH-1:DWIDTH-1]) || !(|sh[2*DWIDTH-1:DWIDTH-1]))
            return sh[DWIDTH-1:0];
        return sh[2*DWIDTH-1] ? MINV : MAXV;
    endfunction

    state_t r_state, w_next;
    logic [2:0] r_step;

    logic signed [DWIDTH-1:0] r_A, r_B, r_C, r_lr;
    logic signed [DWIDTH-1:0] r_wa1, r_wa2, r_wb1, r_wb2, r_wc1, r_wc2;
    logic signed [DWIDTH-1:0] r_bias1, r_bias2, r_e1, r_e2, r_sd1, r_sd2;
    logic signed [DWIDTH-1:0] r_delta1, r_delta2;
    logic signed [DWIDTH-1:0] r_wa1_n, r_wa2_n, r_wb1_n, r_wb2_n, r_wc1_n, r_wc2_n;
    logic signed [DWIDTH-1:0] r_bias1_n, r_bias2_n, r_errA, r_errB, r_errC;
    logic signed [DWIDTH-1:0] w_opA, w_opB, w_prod;

`ifdef OUTPUT_BACKPROP_SIGMOID_DERIV_EN
    localparam logic signed [DWIDTH-1:0] ONE = {{(DWIDTH-1){1'b0}}, 1'b1} << frac;
    logic signed [DWIDTH-1:0] r_out1, r_out2, r_s1, r_s2;
    logic signed [DWIDTH-1:0] w_oneMinus1, w_oneMinus2;
    assign w_oneMinus1 = satSub(ONE, r_out1);
    assign w_oneMinus2 = satSub(ONE, r_out2);
`endif

    // State register and step counter. The step counter restarts whenever
    // the state changes, so it counts cycles within the current state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_step  <= 3'd0;
        end else begin
            r_state <= w_next;
            r_step  <= (w_next != r_state) ? 3'd0 : r_step + 3'd1;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        w_next = r_state;
        busy   = (r_state != IDLE) && (r_state != DONE);
        done   = (r_state == DONE);
        case (r_state)
            IDLE:  if (start) w_next = LOAD;
`ifdef OUTPUT_BACKPROP_SIGMOID_DERIV_EN
            LOAD:  w_next = DERIV;
            DERIV: if (r_step == 3'd3) w_next = SCALE;
`else
            LOAD:  w_next = SCALE;
`endif
            SCALE: if (r_step == 3'd1) w_next = WUPD;
            WUPD:  if (r_step == 3'd5) w_next = BPROP;
            BPROP: if (r_step == 3'd5) w_next = DONE;
            DONE:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Operand mux for the shared multiplier, indexed by state and step.
    always_comb begin
        w_opA = '0;
        w_opB = '0;
        case (r_state)
`ifdef OUTPUT_BACKPROP_SIGMOID_DERIV_EN
            DERIV: begin
                case (r_step)
                    3'd0:    begin w_opA = r_out1; w_opB = w_oneMinus1; end
                    3'd1:    begin w_opA = r_out2; w_opB = w_oneMinus2; end
                    3'd2:    begin w_opA = r_e1;   w_opB = r_s1;        end
                    default: begin w_opA = r_e2;   w_opB = r_s2;        end
                endcase
            end
`endif
            SCALE: begin
                w_opA = r_lr;
                w_opB = r_step[0] ? r_delta2 : r_delta1;
            end
            WUPD: begin
                w_opA = (r_step < 3'd3) ? r_sd1 : r_sd2;
                case (r_step)
                    3'd0, 3'd3: w_opB = r_A;
                    3'd1, 3'd4: w_opB = r_B;
                    default:    w_opB = r_C;
                endcase
            end
            BPROP: begin
                w_opA = r_step[0] ? r_delta2 : r_delta1;
                case (r_step)
                    3'd0:    w_opB = r_wa1;
                    3'd1:    w_opB = r_wa2;
                    3'd2:    w_opB = r_wb1;
                    3'd3:    w_opB = r_wb2;
                    3'd4:    w_opB = r_wc1;
                    default: w_opB = r_wc2;
                endcase
            end
            default: ;
        endcase
    end

    assign w_prod = satMul(w_opA, w_opB);

    // Datapath registers. The inputs are captured once, on the start edge.
    // BPROP reads the captured old weights and never reads the updated ones.
    // In BPROP, each even step opens an error accumulator with its first
    // product, so no separate clear cycle is needed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_A <= '0; r_B <= '0; r_C <= '0; r_lr <= '0;
            r_wa1 <= '0; r_wa2 <= '0; r_wb1 <= '0; r_wb2 <= '0;
            r_wc1 <= '0; r_wc2 <= '0; r_bias1 <= '0; r_bias2 <= '0;
            r_e1 <= '0; r_e2 <= '0; r_sd1 <= '0; r_sd2 <= '0;
            r_delta1 <= '0; r_delta2 <= '0;
            r_wa1_n <= '0; r_wa2_n <= '0; r_wb1_n <= '0; r_wb2_n <= '0;
            r_wc1_n <= '0; r_wc2_n <= '0; r_bias1_n <= '0; r_bias2_n <= '0;
            r_errA <= '0; r_errB <= '0; r_errC <= '0;
`ifdef OUTPUT_BACKPROP_SIGMOID_DERIV_EN
            r_out1 <= '0; r_out2 <= '0; r_s1 <= '0; r_s2 <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_A <= A; r_B <= B; r_C <= C; r_lr <= lr;
                        r_wa1 <= wa1; r_wa2 <= wa2; r_wb1 <= wb1; r_wb2 <= wb2;
                        r_wc1 <= wc1; r_wc2 <= wc2;
                        r_bias1 <= bias1; r_bias2 <= bias2;
                        r_e1 <= satSub(out1, t1);
                        r_e2 <= satSub(out2, t2);
`ifdef OUTPUT_BACKPROP_SIGMOID_DERIV_EN
                        r_out1 <= out1; r_out2 <= out2;
`endif
                    end
                end
                LOAD: begin
                    r_delta1 <= r_e1;
                    r_delta2 <= r_e2;
                end
`ifdef OUTPUT_BACKPROP_SIGMOID_DERIV_EN
                DERIV: begin
                    case (r_step)
                        3'd0:    r_s1 <= w_prod;
                        3'd1:    r_s2 <= w_prod;
                        3'd2:    r_delta1 <= w_prod;
                        default: r_delta2 <= w_prod;
                    endcase
                end
`endif
                SCALE: begin
                    if (r_step[0]) r_sd2 <= w_prod;
                    else           r_sd1 <= w_prod;
                end
                WUPD: begin
                    case (r_step)
                        3'd0: begin
                            r_wa1_n   <= satSub(r_wa1, w_prod);
                            r_bias1_n <= satSub(r_bias1, r_sd1);
                            r_bias2_n <= satSub(r_bias2, r_sd2);
                        end
                        3'd1:    r_wb1_n <= satSub(r_wb1, w_prod);
                        3'd2:    r_wc1_n <= satSub(r_wc1, w_prod);
                        3'd3:    r_wa2_n <= satSub(r_wa2, w_prod);
                        3'd4:    r_wb2_n <= satSub(r_wb2, w_prod);
                        default: r_wc2_n <= satSub(r_wc2, w_prod);
                    endcase
                end
                BPROP: begin
                    case (r_step)
                        3'd0:    r_errA <= w_prod;
                        3'd1:    r_errA <= satAdd(r_errA, w_prod);
                        3'd2:    r_errB <= w_prod;
                        3'd3:    r_errB <= satAdd(r_errB, w_prod);
                        3'd4:    r_errC <= w_prod;
                        default: r_errC <= satAdd(r_errC, w_prod);
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign delta1  = r_delta1;
    assign delta2  = r_delta2;
    assign wa1_n   = r_wa1_n;
    assign wa2_n   = r_wa2_n;
    assign wb1_n   = r_wb1_n;
    assign wb2_n   = r_wb2_n;
    assign wc1_n   = r_wc1_n;
    assign wc2_n   = r_wc2_n;
    assign bias1_n = r_bias1_n;
    assign bias2_n = r_bias2_n;
    assign errA    = r_errA;
    assign errB    = r_errB;
    assign errC    = r_errC;

endmodule

// File: tb/tb_output_layer_backprop.sv
// ============================================================================
// tb_output_layer_backprop
// ----------------------------------------------------------------------------
// Directed bench for output_layer_backprop. When a run starts, the expected
// results are pushed onto a queue. When done pulses, an entry is popped and
// compared with the outputs.
// ============================================================================
module tb_output_layer_backprop;

`ifdef OUTPUT_BACKPROP_SIGMOID_DERIV_EN
    localparam int LAT = 19;
`else
    localparam int LAT = 15;
`endif

    localparam logic [31:0] ONE     = 32'h0100_0000;
    localparam logic [31:0] HALF    = 32'h0080_0000;
    localparam logic [31:0] QUARTER = 32'h0040_0000;

    typedef struct {
        logic [31:0] A, B, C, out1, out2, t1, t2;
        logic [31:0] wa1, wa2, wb1, wb2, wc1, wc2, bias1, bias2, lr;
    } stim_t;

    typedef struct {
        logic [31:0] delta1, delta2, wa1, wb1, wc1, wa2, wb2, wc2;
        logic [31:0] bias1, bias2, errA, errB, errC;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic [31:0] A = '0, B = '0, C = '0, out1 = '0, out2 = '0, t1 = '0, t2 = '0;
    logic [31:0] wa1 = '0, wa2 = '0, wb1 = '0, wb2 = '0, wc1 = '0, wc2 = '0;
    logic [31:0] bias1 = '0, bias2 = '0, lr = '0;
    logic        busy, done;
    logic [31:0] delta1, delta2, wa1_n, wa2_n, wb1_n, wb2_n, wc1_n, wc2_n;
    logic [31:0] bias1_n, bias2_n, errA, errB, errC;

    res_t queue_exp[$];
    int   compareCount = 0;
    int   failCount = 0;
    int   cyc = 0;
    int   startCyc = 0;

    output_layer_backprop #(.DWIDTH(32), .frac(24)) dut (
        .clk(clk), .rst(rst), .start(start),
        .A(A), .B(B), .C(C), .out1(out1), .out2(out2), .t1(t1), .t2(t2),
        .wa1(wa1), .wa2(wa2), .wb1(wb1), .wb2(wb2), .wc1(wc1), .wc2(wc2),
        .bias1(bias1), .bias2(bias2), .lr(lr),
        .busy(busy), .done(done),
        .delta1(delta1), .delta2(delta2),
        .wa1_n(wa1_n), .wa2_n(wa2_n), .wb1_n(wb1_n), .wb2_n(wb2_n),
        .wc1_n(wc1_n), .wc2_n(wc2_n),
        .bias1_n(bias1_n), .bias2_n(bias2_n),
        .errA(errA), .errB(errB), .errC(errC)
    );

    // Free-running clock. A counter of rising edges serves as the cycle
    // reference.
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compareCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a stimulus vector and raise start so that the next rising edge
    // samples it. That edge is the start edge N. Push the expected results.
    task automatic applyStimulus(input stim_t s, input res_t e);
        @(negedge clk);
        A = s.A; B = s.B; C = s.C; out1 = s.out1; out2 = s.out2; t1 = s.t1; t2 = s.t2;
        wa1 = s.wa1; wa2 = s.wa2; wb1 = s.wb1; wb2 = s.wb2; wc1 = s.wc1; wc2 = s.wc2;
        bias1 = s.bias1; bias2 = s.bias2; lr = s.lr;
        start = 1'b1;
        startCyc = cyc + 1;
        queue_exp.push_back(e);
        @(negedge clk);
        start = 1'b0;
        checkVal("busy_after_start", {31'b0, busy}, 32'd1);
    endtask

    // Wait, with a bound, for done. Check its cycle and that it lasts a
    // single cycle, then compare the outputs with the popped expectation.
    task automatic checkOutput();
        res_t e;
        int   waited = 0;
        while (done !== 1'b1 && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        checkVal("done_seen", {31'b0, done}, 32'd1);
        checkVal("latency", cyc - startCyc, LAT);
        checkVal("busy_at_done", {31'b0, busy}, 32'd0);
        if (queue_exp.size() == 0) begin
            checkVal("scoreboard_nonempty", 32'd0, 32'd1);
        end else begin
            e = queue_exp.pop_front();
            checkVal("delta1", delta1, e.delta1);
            checkVal("delta2", delta2, e.delta2);
            checkVal("wa1_n", wa1_n, e.wa1);
            checkVal("wb1_n", wb1_n, e.wb1);
            checkVal("wc1_n", wc1_n, e.wc1);
            checkVal("wa2_n", wa2_n, e.wa2);
            checkVal("wb2_n", wb2_n, e.wb2);
            checkVal("wc2_n", wc2_n, e.wc2);
            checkVal("bias1_n", bias1_n, e.bias1);
            checkVal("bias2_n", bias2_n, e.bias2);
            checkVal("errA", errA, e.errA);
            checkVal("errB", errB, e.errB);
            checkVal("errC", errC, e.errC);
        end
        @(negedge clk);
        checkVal("done_single_pulse", {31'b0, done}, 32'd0);
    endtask

    initial begin
        stim_t basic, sat, deriv;
        res_t  basicExp, satExp, derivExp;
        int    extraDone;

        basic = '{A: ONE, B: 32'h0200_0000, C: 32'hFF00_0000,
                  out1: ONE, out2: 32'h0, t1: HALF, t2: QUARTER,
                  wa1: HALF, wa2: HALF, wb1: HALF, wb2: HALF, wc1: HALF, wc2: HALF,
                  bias1: 32'h0, bias2: 32'h0, lr: HALF};
        basicExp = '{delta1: 32'h0080_0000, delta2: 32'hFFC0_0000,
                     wa1: 32'h0040_0000, wb1: 32'h0000_0000, wc1: 32'h00C0_0000,
                     wa2: 32'h00A0_0000, wb2: 32'h00C0_0000, wc2: 32'h0060_0000,
                     bias1: 32'hFFC0_0000, bias2: 32'h0020_0000,
                     errA: 32'h0020_0000, errB: 32'h0020_0000, errC: 32'h0020_0000};

        sat = basic;
        sat.out1 = 32'h7F00_0000; sat.t1 = 32'h8100_0000;
        sat.lr = ONE; sat.wa1 = 32'h8000_0000;
        satExp = '{delta1: 32'h7FFF_FFFF, delta2: 32'hFFC0_0000,
                   wa1: 32'h8000_0000, wb1: 32'h8080_0001, wc1: 32'h7FFF_FFFF,
                   wa2: 32'h00C0_0000, wb2: 32'h0100_0000, wc2: 32'h0040_0000,
                   bias1: 32'h8000_0001, bias2: 32'h0040_0000,
                   errA: 32'h8000_0000, errB: 32'h3FDF_FFFF, errC: 32'h3FDF_FFFF};

        deriv = basic;
        deriv.out1 = HALF; deriv.t1 = 32'h0;
        derivExp = '{delta1: 32'h0020_0000, delta2: 32'h0000_0000,
                     wa1: 32'h0070_0000, wb1: 32'h0060_0000, wc1: 32'h0090_0000,
                     wa2: HALF, wb2: HALF, wc2: HALF,
                     bias1: 32'hFFF0_0000, bias2: 32'h0000_0000,
                     errA: 32'h0010_0000, errB: 32'h0010_0000, errC: 32'h0010_0000};

        $display("[TB] start, latency %0d", LAT);

        // Reset state
        repeat (2) @(negedge clk);
        checkVal("reset_busy", {31'b0, busy}, 32'd0);
        checkVal("reset_done", {31'b0, done}, 32'd0);
        checkVal("reset_errA", errA, 32'h0);
        rst = 1'b1;
        @(negedge clk);

`ifdef OUTPUT_BACKPROP_SIGMOID_DERIV_EN
        // Sigmoid-derivative path
        applyStimulus(deriv, derivExp);
        checkOutput();
`else
        // Basic update
        applyStimulus(basic, basicExp);
        checkOutput();

        // A start while busy is ignored. Expect one done and the same results.
        applyStimulus(basic, basicExp);
        while (cyc < startCyc + 4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput();
        extraDone = 0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1) extraDone++;
        end
        checkVal("no_extra_done", extraDone, 32'd0);

        // Changing the inputs after the start edge does not affect the result.
        applyStimulus(basic, basicExp);
        A = 32'h0; lr = 32'h0; wa1 = 32'h0; out1 = 32'h0; bias1 = ONE;
        checkOutput();

        // Saturation
        applyStimulus(sat, satExp);
        checkOutput();

        // Reset mid-operation clears everything at once.
        applyStimulus(basic, basicExp);
        while (cyc < startCyc + 7) @(negedge clk);
        rst = 1'b0;
        #1;
        void'(queue_exp.pop_front());
        checkVal("midreset_busy", {31'b0, busy}, 32'd0);
        checkVal("midreset_done", {31'b0, done}, 32'd0);
        checkVal("midreset_outputs",
                 delta1 | delta2 | wa1_n | wa2_n | wb1_n | wb2_n | wc1_n | wc2_n |
                 bias1_n | bias2_n | errA | errB | errC, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        applyStimulus(basic, basicExp);
        checkOutput();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
